// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI3 slave backed by a byte-enabled synchronous RAM, with independent
// single-outstanding write/read FSMs and a 2-entry read skid buffer.
module axi_slv_mem #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [31:0]             s_axi_awaddr,
  input  logic [3:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_wid,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [31:0]             s_axi_araddr,
  input  logic [3:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             WBEATS_REG,
  output logic [31:0]             RBEATS_REG
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = 3'($clog2(STRB));
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic                  rdy_q;
  wstate_e               wst_q, wst_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [MEM_AW-1:0]     waddr_q, waddr_d;
  logic [3:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                  wfix_q, wfix_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           wbeats_q, wbeats_d, rbeats_q, rbeats_d;
  rstate_e               rst_q, rst_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [MEM_AW-1:0]     raddr_q, raddr_d, ra;
  logic [3:0]            rlen_q, rlen_d, r_len, r_idx;
  logic                  rfix_q, rfix_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [4:0]            rcnt_q, rcnt_d;
  logic                  s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0] rd_q, push_data;
  logic [DATA_WIDTH-1:0] f_d0_q, f_d0_d, f_d1_q, f_d1_d;
  logic                  f_l0_q, f_l0_d, f_l1_q, f_l1_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  aw_hs, w_hs, ar_hs, r_pop, issue, re;
  logic [2:0]            occ;
  logic                  unused_ok;
  assign unused_ok = ^{s_axi_wid, s_axi_awaddr[2:0], s_axi_araddr[2:0]};
  assign s_axi_awready = rdy_q & (wst_q == W_IDLE);
  assign s_axi_wready  = wst_q == W_DATA;
  assign s_axi_bvalid  = wst_q == W_RESP;
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = rdy_q & (rst_q == R_IDLE);
  assign s_axi_rvalid  = fcnt_q != 2'd0;
  assign s_axi_rdata   = f_d0_q;
  assign s_axi_rlast   = s_axi_rvalid & f_l0_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign WBEATS_REG    = wbeats_q;
  assign RBEATS_REG    = rbeats_q;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_pop = s_axi_rvalid & s_axi_rready;
  always_comb begin
    wst_d    = wst_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wfix_d   = wfix_q;
    wcnt_d   = wcnt_q;
    bresp_d  = bresp_q;
    wbeats_d = wbeats_q + 32'(w_hs);
    case (wst_q)
      W_IDLE: if (aw_hs) begin
        wst_d   = W_DATA;
        wid_d   = s_axi_awid;
        waddr_d = s_axi_awaddr[MEM_AW+2:3];
        wlen_d  = s_axi_awlen;
        wfix_d  = s_axi_awburst == 2'b00;
        wcnt_d  = 4'd0;
        bresp_d = (|s_axi_awaddr[31:MEM_AW+3]) ? 2'b11 :
                  (s_axi_awburst[1] || s_axi_awsize != SIZE) ? 2'b10 : 2'b00;
      end
      W_DATA: if (w_hs) begin
        wcnt_d  = wcnt_q + 4'd1;
        waddr_d = wfix_q ? waddr_q : waddr_q + MEM_AW'(1);
        if (s_axi_wlast != (wcnt_q == wlen_q) && bresp_q != 2'b11) bresp_d = 2'b10;
        if (wcnt_q == wlen_q) wst_d = W_RESP;
      end
      default: if (s_axi_bready) wst_d = W_IDLE;
    endcase
  end
  // Issue a RAM read only while the RAM stage plus skid buffer keeps at most two beats in flight.
  always_comb begin
    rst_d     = rst_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rfix_d    = rfix_q;
    rresp_d   = rresp_q;
    rcnt_d    = rcnt_q;
    rbeats_d  = rbeats_q + 32'(r_pop);
    occ       = {1'b0, fcnt_q} + {2'b0, s1_v_q} - {2'b0, r_pop};
    issue     = rst_q == R_DATA && rcnt_q <= {1'b0, rlen_q} && occ < 3'd2;
    re        = ar_hs | issue;
    ra        = ar_hs ? s_axi_araddr[MEM_AW+2:3] : raddr_q;
    r_len     = ar_hs ? s_axi_arlen : rlen_q;
    r_idx     = ar_hs ? 4'd0 : rcnt_q[3:0];
    s1_v_d    = re;
    s1_last_d = re & (r_idx == r_len);
    if (re) begin
      raddr_d = (ar_hs ? s_axi_arburst == 2'b00 : rfix_q) ? ra : ra + MEM_AW'(1);
      rcnt_d  = {1'b0, r_idx} + 5'd1;
    end
    if (ar_hs) begin
      rst_d   = R_DATA;
      rid_d   = s_axi_arid;
      rlen_d  = s_axi_arlen;
      rfix_d  = s_axi_arburst == 2'b00;
      rresp_d = (|s_axi_araddr[31:MEM_AW+3]) ? 2'b11 :
                (s_axi_arburst[1] || s_axi_arsize != SIZE) ? 2'b10 : 2'b00;
    end
    if (r_pop && s_axi_rlast) rst_d = R_IDLE;
    push_data = rresp_q == 2'b11 ? '0 : rd_q;
    fcnt_d    = fcnt_q + {1'b0, s1_v_q} - {1'b0, r_pop};
    f_d0_d    = r_pop ? f_d1_q : f_d0_q;
    f_l0_d    = r_pop ? f_l1_q : f_l0_q;
    f_d1_d    = f_d1_q;
    f_l1_d    = f_l1_q;
    if (s1_v_q && (fcnt_q - {1'b0, r_pop}) == 2'd0) begin
      f_d0_d = push_data;
      f_l0_d = s1_last_q;
    end
    if (s1_v_q && (fcnt_q - {1'b0, r_pop}) != 2'd0) begin
      f_d1_d = push_data;
      f_l1_d = s1_last_q;
    end
  end
  // Memory survives reset; nonblocking read gives read-first on collisions.
  always_ff @(posedge s_axi_aclk) begin
    if (w_hs && bresp_q != 2'b11)
      for (int b = 0; b < STRB; b++)
        if (s_axi_wstrb[b]) mem[waddr_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    if (re) rd_q <= mem[ra];
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rdy_q     <= 1'b0;
      wst_q     <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wfix_q    <= 1'b0;
      wcnt_q    <= '0;
      bresp_q   <= '0;
      wbeats_q  <= '0;
      rbeats_q  <= '0;
      rst_q     <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rfix_q    <= 1'b0;
      rresp_q   <= '0;
      rcnt_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      f_d0_q    <= '0;
      f_d1_q    <= '0;
      f_l0_q    <= 1'b0;
      f_l1_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      rdy_q     <= 1'b1;
      wst_q     <= wst_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wfix_q    <= wfix_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
      wbeats_q  <= wbeats_d;
      rbeats_q  <= rbeats_d;
      rst_q     <= rst_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rfix_q    <= rfix_d;
      rresp_q   <= rresp_d;
      rcnt_q    <= rcnt_d;
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_last_d;
      f_d0_q    <= f_d0_d;
      f_d1_q    <= f_d1_d;
      f_l0_q    <= f_l0_d;
      f_l1_q    <= f_l1_d;
      fcnt_q    <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_axi_slv_mem.sv
// tb_axi_slv_mem: directed plus randomized bursts for axi_slv_mem, checked against a
// word-array reference memory and response rules.
module tb_axi_slv_mem;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [5:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wbeats, rbeats;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  axi_slv_mem #(.ID_WIDTH(6), .DATA_WIDTH(64), .MEM_AW(10)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .WBEATS_REG(wbeats), .RBEATS_REG(rbeats)
  );
  logic [63:0] ref_mem [1024];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [31:0] exp_wb = 0, exp_rb = 0;
  int n_pass = 0, n_tot = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [1:0] burst,
                                          input logic [2:0] size);
    return (addr[31:13] != 0) ? 2'b11 : (burst[1] || size != 3'd3) ? 2'b10 : 2'b00;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // bad: index of the beat whose wlast is inverted, -1 for none
  task automatic wr(input logic [5:0] id, input logic [31:0] addr, input int len,
                    input logic [1:0] burst, input logic [2:0] size, input int bad);
    int cyc;
    logic [1:0] r;
    logic [9:0] a;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1;
    cyc = 0;
    while (!awready && cyc < 50) begin tick; cyc++; end
    chk("awready", awready, 1);
    tick;
    awvalid = 0;
    chk("wready_lat", wready, 1);
    r = exp_resp(addr, burst, size);
    a = addr[12:3];
    for (int i = 0; i <= len; i++) begin
      wid = id; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ (i == bad); wvalid = 1;
      if (r != 2'b11)
        for (int b = 0; b < 8; b++) if (ws[i][b]) ref_mem[a][8*b +: 8] = wd[i][8*b +: 8];
      if (burst != 2'b00) a++;
      tick;
    end
    wvalid = 0; wlast = 0;
    if (bad >= 0 && r == 2'b00) r = 2'b10;
    exp_wb += 32'(len + 1);
    chk("bvalid_lat", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, r);
    bready = 1;
    tick;
    bready = 0;
    chk("b_done", bvalid, 0);
    chk("wbeats", wbeats, exp_wb);
  endtask
  // mode: 0 rready held high, 1 toggling, 2 random
  task automatic rd(input logic [5:0] id, input logic [31:0] addr, input int len,
                    input logic [1:0] burst, input logic [2:0] size, input int mode);
    int cyc, n;
    logic [1:0] r;
    logic [9:0] a;
    logic pv, prd, plast;
    logic [63:0] pdata;
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1;
    cyc = 0;
    while (!arready && cyc < 50) begin tick; cyc++; end
    chk("arready", arready, 1);
    tick;
    arvalid = 0;
    chk("rvalid_t1", rvalid, 0);
    tick;
    chk("rvalid_t2", rvalid, 1);
    r = exp_resp(addr, burst, size);
    a = addr[12:3];
    n = 0; cyc = 0; pv = 0; prd = 0; plast = 0; pdata = 0;
    while (n <= len && cyc < 400) begin
      if (pv && !prd) begin
        chk("stall_valid", rvalid, 1);
        chk("stall_data", rdata, pdata);
        chk("stall_last", rlast, plast);
      end
      rready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      pv = rvalid; prd = rready; pdata = rdata; plast = rlast;
      if (rvalid && rready) begin
        chk("rdata", rdata, r == 2'b11 ? 64'd0 : ref_mem[a]);
        chk("rlast", rlast, n == len);
        chk("rresp", rresp, r);
        chk("rid", rid, id);
        if (burst != 2'b00) a++;
        n++;
      end
      tick;
      cyc++;
    end
    rready = 0;
    exp_rb += 32'(len + 1);
    chk("rbeat_count", 64'(n), 64'(len + 1));
    chk("rvalid_end", rvalid, 0);
    chk("rbeats", rbeats, exp_rb);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] addr;
    logic [63:0] old;
    int len, bad;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3; awburst = 1; wid = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3; arburst = 1;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_wbeats", wbeats, 0);
    chk("rst_rbeats", rbeats, 0);
    #2 rst_n = 1;
    tick;
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 16; j++) begin wd[j] = {$urandom, $urandom}; ws[j] = 8'hFF; end
      wr(6'(i), 32'(i * 128), 15, 2'b01, 3'd3, -1);
    end
    for (int j = 0; j < 4; j++) begin wd[j] = 64'(j + 1); ws[j] = 8'hFF; end
    wr(6'h05, 32'h100, 3, 2'b01, 3'd3, -1);
    rd(6'h06, 32'h100, 3, 2'b01, 3'd3, 0);
    wd[0] = '1; ws[0] = 8'hFF;
    wr(6'h07, 32'h200, 0, 2'b01, 3'd3, -1);
    wd[0] = '0; ws[0] = 8'h0F;
    wr(6'h08, 32'h200, 0, 2'b01, 3'd3, -1);
    rd(6'h09, 32'h200, 0, 2'b01, 3'd3, 0);
    rd(6'h0A, 32'h000, 15, 2'b01, 3'd3, 1);
    wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
    wr(6'h0B, 32'h8000_0000, 0, 2'b01, 3'd3, -1);
    rd(6'h0C, 32'h0, 0, 2'b01, 3'd3, 0);
    rd(6'h0D, 32'h8000_0000, 1, 2'b01, 3'd3, 0);
    for (int j = 0; j < 4; j++) begin wd[j] = {$urandom, $urandom}; ws[j] = 8'hFF; end
    wr(6'h0E, 32'h300, 3, 2'b01, 3'd3, 1);
    rd(6'h0F, 32'h300, 3, 2'b01, 3'd3, 2);
    wd[0] = 64'hAAAA; wd[1] = 64'hBBBB; ws[0] = 8'hFF; ws[1] = 8'hFF;
    wr(6'h10, 32'h1FF8, 1, 2'b01, 3'd3, -1);
    rd(6'h11, 32'h1FF8, 1, 2'b01, 3'd3, 0);
    rd(6'h12, 32'h0, 0, 2'b01, 3'd3, 0);
    old = ref_mem[10'h50];
    awid = 6'h13; awaddr = 32'h280; awlen = 0; awsize = 3; awburst = 1; awvalid = 1;
    tick;
    awvalid = 0;
    wid = 6'h13; wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF; wlast = 1; wvalid = 1;
    arid = 6'h14; araddr = 32'h280; arlen = 0; arsize = 3; arburst = 1; arvalid = 1;
    tick;
    wvalid = 0; wlast = 0; arvalid = 0; bready = 1; rready = 1;
    tick;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata", rdata, old);
    tick;
    bready = 0; rready = 0;
    ref_mem[10'h50] = 64'h1234_5678_9ABC_DEF0;
    exp_wb++; exp_rb++;
    chk("coll_wbeats", wbeats, exp_wb);
    rd(6'h15, 32'h280, 0, 2'b01, 3'd3, 0);
    for (int k = 0; k < 40; k++) begin
      addr = 32'($urandom_range(0, 1023)) << 3;
      if ($urandom_range(0, 7) == 0) addr[31:13] = 19'($urandom_range(1, 524287));
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 16; j++) begin wd[j] = {$urandom, $urandom}; ws[j] = 8'($urandom); end
        bad = $urandom_range(0, 3) == 0 ? $urandom_range(0, len) : -1;
        wr(6'($urandom), addr, len, 2'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : 3'd3, bad);
      end else
        rd(6'($urandom), addr, len, 2'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : 3'd3, $urandom_range(0, 2));
    end
    arid = 6'h20; araddr = 32'h400; arlen = 7; arsize = 3; arburst = 1; arvalid = 1;
    tick;
    arvalid = 0; rready = 1;
    tick;
    tick;
    chk("mid_rvalid", rvalid, 1);
    chk("mid_beat2", rdata, ref_mem[10'h81]);
    rst_n = 0;
    #1;
    rready = 0;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 0);
    chk("mid_rst_rbeats", rbeats, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    exp_wb = 0; exp_rb = 0;
    tick;
    chk("mid_rel_arready", arready, 1);
    chk("mid_rel_awready", awready, 1);
    rd(6'h21, 32'h400, 7, 2'b01, 3'd3, 2);
    rd(6'h22, 32'h100, 3, 2'b01, 3'd3, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
